// File: rtl/issue_scheduler_if.sv
// Bundle between the instruction source, the issue scheduler and decode.
// The slave modport is the scheduler's view.
interface issue_scheduler_if #(
  parameter int DEPTH    = 4,
  parameter int OPCODE_W = 4,
  parameter int DATA_W   = 8,
  parameter int REG_W    = 3
);
  localparam int NREG = 1 << REG_W;
  localparam int QW   = $clog2(DEPTH) + 1;

  logic                instv;
  logic [OPCODE_W-1:0] opcode;
  logic [DATA_W-1:0]   imm;
  logic [REG_W-1:0]    src1;
  logic [REG_W-1:0]    src2;
  logic [REG_W-1:0]    dst;
  logic                stall;
  logic                in_ready;
  logic                ovf;
  logic                iss_valid;
  logic [OPCODE_W-1:0] iss_opcode;
  logic [DATA_W-1:0]   iss_imm;
  logic [REG_W-1:0]    iss_src1;
  logic [REG_W-1:0]    iss_src2;
  logic [REG_W-1:0]    iss_dst;
  logic [QW-1:0]       q_count;
  logic [NREG-1:0]     busy;

  modport slave (
    input  instv, opcode, imm, src1, src2, dst, stall,
    output in_ready, ovf, iss_valid, iss_opcode, iss_imm, iss_src1, iss_src2,
           iss_dst, q_count, busy
  );

  modport master (
    output instv, opcode, imm, src1, src2, dst, stall,
    input  in_ready, ovf, iss_valid, iss_opcode, iss_imm, iss_src1, iss_src2,
           iss_dst, q_count, busy
  );
endinterface

// File: rtl/issue_scheduler.sv
// In-order issue controller: instruction FIFO, countdown scoreboard, registered issue stage.
// Define ISSUE_SCHED_FWD_EN when the datapath bypasses ALU results (RAW blocks only one cycle).
module issue_scheduler #(
  parameter int DEPTH      = 4,
  parameter int WB_LAT     = 3,
  parameter int OPCODE_W   = 4,
  parameter int DATA_W     = 8,
  parameter int REG_W      = 3,
  parameter int NOP_OPCODE = 0
) (
  input  logic               clock,
  input  logic               reset,
  issue_scheduler_if.slave   bus
);
  localparam int NREG = 1 << REG_W;
  localparam int PW   = $clog2(DEPTH);
  localparam int QW   = PW + 1;
  localparam int CW   = $clog2(WB_LAT + 1);
  localparam logic [CW-1:0]       LAT = CW'(WB_LAT);
  localparam logic [OPCODE_W-1:0] NOP = OPCODE_W'(NOP_OPCODE);

  logic [OPCODE_W-1:0] mem_op   [DEPTH];
  logic [DATA_W-1:0]   mem_imm  [DEPTH];
  logic [REG_W-1:0]    mem_src1 [DEPTH];
  logic [REG_W-1:0]    mem_src2 [DEPTH];
  logic [REG_W-1:0]    mem_dst  [DEPTH];

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                iss_valid_q, iss_valid_d;
  logic [OPCODE_W-1:0] iss_op_q, iss_op_d;
  logic [DATA_W-1:0]   iss_imm_q, iss_imm_d;
  logic [REG_W-1:0]    iss_src1_q, iss_src1_d;
  logic [REG_W-1:0]    iss_src2_q, iss_src2_d;
  logic [REG_W-1:0]    iss_dst_q, iss_dst_d;

  logic [NREG-1:0][CW-1:0] cnt_all;
  logic [NREG-1:0]         busy_w;

  logic                in_ready_w, push, drop, pop, head_nop, head_blocked;
  logic [OPCODE_W-1:0] head_op;
  logic [REG_W-1:0]    head_src1, head_src2, head_dst;

  function automatic logic src_blocked(input logic [CW-1:0] c);
`ifdef ISSUE_SCHED_FWD_EN
    return c == LAT;
`else
    return c != '0;
`endif
  endfunction

  assign in_ready_w = count_q < QW'(DEPTH);
  assign push       = bus.instv & in_ready_w;
  assign drop       = bus.instv & ~in_ready_w;

  assign head_op   = mem_op[rd_ptr_q];
  assign head_src1 = mem_src1[rd_ptr_q];
  assign head_src2 = mem_src2[rd_ptr_q];
  assign head_dst  = mem_dst[rd_ptr_q];
  assign head_nop  = head_op == NOP;

  assign head_blocked = ~head_nop &
                        (src_blocked(cnt_all[head_src1]) | src_blocked(cnt_all[head_src2]));
  assign pop = (count_q != '0) & ~bus.stall & ~head_blocked;

  // Storage needs no reset: only the pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_op[wr_ptr_q]   <= bus.opcode;
      mem_imm[wr_ptr_q]  <= bus.imm;
      mem_src1[wr_ptr_q] <= bus.src1;
      mem_src2[wr_ptr_q] <= bus.src2;
      mem_dst[wr_ptr_q]  <= bus.dst;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      logic [CW-1:0] cnt_q, cnt_d;
      logic          load;

      assign load = pop & ~head_nop & (head_dst == REG_W'(gi));

      // A load overrides the decrement, which makes WAW reissue restart the countdown.
      always_comb begin
        cnt_d = cnt_q;
        if (!bus.stall) begin
          if (load) begin
            cnt_d = LAT;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign cnt_all[gi] = cnt_q;
      assign busy_w[gi]  = cnt_q != '0;
    end
  endgenerate

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + QW'(push) - QW'(pop);
    ovf_d       = ovf_q | drop;
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_imm_d   = iss_imm_q;
    iss_src1_d  = iss_src1_q;
    iss_src2_d  = iss_src2_q;
    iss_dst_d   = iss_dst_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (!bus.stall) begin
      iss_valid_d = pop;
      if (pop) begin
        iss_op_d   = head_op;
        iss_imm_d  = mem_imm[rd_ptr_q];
        iss_src1_d = head_src1;
        iss_src2_d = head_src2;
        iss_dst_d  = head_dst;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_imm_q   <= '0;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
      iss_dst_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_imm_q   <= iss_imm_d;
      iss_src1_q  <= iss_src1_d;
      iss_src2_q  <= iss_src2_d;
      iss_dst_q   <= iss_dst_d;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.ovf        = ovf_q;
  assign bus.iss_valid  = iss_valid_q;
  assign bus.iss_opcode = iss_op_q;
  assign bus.iss_imm    = iss_imm_q;
  assign bus.iss_src1   = iss_src1_q;
  assign bus.iss_src2   = iss_src2_q;
  assign bus.iss_dst    = iss_dst_q;
  assign bus.q_count    = count_q;
  assign bus.busy       = busy_w;
endmodule
